max_pool_engine: RTL and testbench

- Autonomous 2-D max-pooling engine for a square image of ROW_SIZE x ROW_SIZE unsigned pixels held in an input BRAM.
- Scans non-overlapping KERNEL_DIM x KERNEL_DIM windows in raster order (stride = KERNEL_DIM).
- Writes one max value per window to an output BRAM at sequential addresses 0..OUT_SIZE^2-1, where OUT_SIZE = ROW_SIZE/KERNEL_DIM.
- Runs one frame after each reset release, then idles.

---
 rtl/max_pool_engine.sv | 116 +++++++++++
 tb/tb_max_pool_engine.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/max_pool_engine.sv
// Non-overlapping KERNEL_DIM x KERNEL_DIM max-pooling over a ROW_SIZE x ROW_SIZE
// image held in a registered-read BRAM; one frame per reset release.
module max_pool_engine #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8,
    parameter int KERNEL_DIM = 2,
    parameter int ROW_SIZE   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_en
);
    localparam int KK       = KERNEL_DIM * KERNEL_DIM;
    localparam int OUT_SIZE = ROW_SIZE / KERNEL_DIM;
    localparam int NWIN     = OUT_SIZE * OUT_SIZE;
    localparam int CW       = $clog2(KK + 1);
    localparam bit SINGLE   = (KK == 1);

    localparam logic [CW-1:0]         KK_LAST   = CW'(KK - 1);
    localparam logic [ADDR_WIDTH-1:0] K_A       = ADDR_WIDTH'(KERNEL_DIM);
    localparam logic [ADDR_WIDTH-1:0] R_A       = ADDR_WIDTH'(ROW_SIZE);
    localparam logic [ADDR_WIDTH-1:0] KC_LAST   = ADDR_WIDTH'(KERNEL_DIM - 1);
    localparam logic [ADDR_WIDTH-1:0] COL_LAST  = ADDR_WIDTH'(ROW_SIZE - KERNEL_DIM);
    localparam logic [ADDR_WIDTH-1:0] BAND_STEP = ADDR_WIDTH'(KERNEL_DIM + (KERNEL_DIM - 1) * ROW_SIZE);
    localparam logic [ADDR_WIDTH-1:0] WIN_LAST  = ADDR_WIDTH'(NWIN - 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t                state;
    logic [CW-1:0]         kern_count;
    logic [ADDR_WIDTH-1:0] base_addr, col, row_off, kc, out_idx;
    logic [ADDR_WIDTH-1:0] kc_nxt, row_nxt, base_nxt, col_nxt;
    logic [DATA_WIDTH-1:0] max_val, win_max;

    // rd_addr is registered, so the address for element k+1 is formed during element k
    always_comb begin
        kc_nxt  = kc + 1'b1;
        row_nxt = row_off;
        if (kc == KC_LAST) begin
            kc_nxt  = '0;
            row_nxt = row_off + R_A;
        end
        col_nxt  = col + K_A;
        base_nxt = base_addr + K_A;
        if (col == COL_LAST) begin
            col_nxt  = '0;
            base_nxt = base_addr + BAND_STEP;
        end
    end

    always_comb begin
        win_max = (SINGLE || rd_data > max_val) ? rd_data : max_val;
    end

    assign wr_en   = (state == WRITE);
    assign wr_addr = out_idx;
    assign wr_data = wr_en ? win_max : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            kern_count <= '0;
            base_addr  <= '0;
            col        <= '0;
            row_off    <= '0;
            kc         <= '0;
            out_idx    <= '0;
            max_val    <= '0;
            rd_addr    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    kern_count <= '0;
                    kc         <= '0;
                    row_off    <= '0;
                    rd_addr    <= base_addr;
                    state      <= READ;
                end
                READ: begin
                    // data for element k-1 is on rd_data while element k is addressed
                    if (kern_count == CW'(1))
                        max_val <= rd_data;
                    else if (kern_count > CW'(1))
                        max_val <= win_max;
                    if (kern_count == KK_LAST) begin
                        state <= WRITE;
                    end else begin
                        kern_count <= kern_count + 1'b1;
                        kc         <= kc_nxt;
                        row_off    <= row_nxt;
                        rd_addr    <= base_addr + row_nxt + kc_nxt;
                    end
                end
                WRITE: begin
                    kern_count <= '0;
                    kc         <= '0;
                    row_off    <= '0;
                    if (out_idx == WIN_LAST) begin
                        state <= DONE;
                    end else begin
                        out_idx   <= out_idx + 1'b1;
                        base_addr <= base_nxt;
                        col       <= col_nxt;
                        rd_addr   <= base_nxt;
                        state     <= READ;
                    end
                end
                default: state <= DONE;
            endcase
        end
    end
endmodule

// File: tb/tb_max_pool_engine.sv
// Directed bench for max_pool_engine: default 8x8/2x2 instance plus a 4x4/2x2 instance,
// each with bench-side input BRAM (registered read) and output BRAM (mem / alt_mem).
module tb_max_pool_engine;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       alt_rst = 1'b0;
    logic [5:0] rd_addr, wr_addr;
    logic [7:0] rd_data, wr_data;
    logic       wr_en;
    logic [3:0] alt_rd_addr, alt_wr_addr;
    logic [7:0] alt_rd_data, alt_wr_data;
    logic       alt_wr_en;

    logic [7:0] in_mem [64];
    logic [7:0] mem [64];
    logic [7:0] alt_in_mem [16];
    logic [7:0] alt_mem [16];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    max_pool_engine u_dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en)
    );

    max_pool_engine #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .KERNEL_DIM(2), .ROW_SIZE(4)) u_alt (
        .clk(clk), .rst(alt_rst), .rd_addr(alt_rd_addr), .rd_data(alt_rd_data),
        .wr_addr(alt_wr_addr), .wr_data(alt_wr_data), .wr_en(alt_wr_en)
    );

    always @(posedge clk) begin
        rd_data     <= in_mem[rd_addr];
        alt_rd_data <= alt_in_mem[alt_rd_addr];
        if (wr_en) mem[wr_addr] <= wr_data;
        if (alt_wr_en) alt_mem[alt_wr_addr] <= alt_wr_data;
    end

    typedef struct {
        int e;
        int rd;
        int we;
        int wa;
        int wd;
    } cyc_t;

    cyc_t ctab [15];
    int   exp1 [16];
    int   exp2 [16];
    int   img1 [64];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ti;
        int writes;

        img1 = '{2,34,18,23,45,11,8,27, 19,21,33,26,39,17,14,36,
                 44,13,28,30,10,47,25,7, 38,32,22,4,9,50,12,6,
                 24,41,43,3,16,20,46,1, 35,31,29,15,48,5,37,42,
                 40,49,0,52,51,53,54,55, 56,57,58,59,60,61,62,63};
        exp1 = '{34,33,45,36, 44,30,50,25, 41,43,48,46, 57,59,61,63};
        // edge count after reset release -> rd_addr, wr_en, wr_addr, wr_data
        ctab = '{'{1, 0,0,0,0},  '{2, 1,0,0,0},  '{3, 8,0,0,0},  '{4, 9,0,0,0},
                 '{5, 9,1,0,34}, '{6, 2,0,0,0},  '{7, 3,0,0,0},  '{8,10,0,0,0},
                 '{9,11,0,0,0},  '{10,11,1,1,33},'{20,15,1,3,36},'{21,16,0,0,0},
                 '{22,17,0,0,0}, '{24,25,0,0,0}, '{25,25,1,4,44}};
        for (int i = 0; i < 64; i++) begin
            in_mem[i] = 8'(img1[i]);
            mem[i]    = 8'h00;
        end

        // ---- reset state
        repeat (3) step();
        chk("reset_rd_addr", int'(rd_addr), 0);
        chk("reset_wr_en",   int'(wr_en),   0);
        chk("reset_wr_addr", int'(wr_addr), 0);
        chk("reset_wr_data", int'(wr_data), 0);

        // ---- frame 1 with cycle trace
        @(negedge clk) rst = 1'b1;
        ti = 0;
        writes = 0;
        for (int e = 1; e <= 81; e++) begin
            step();
            if (ti < 15 && ctab[ti].e == e) begin
                chk($sformatf("e%0d_rd_addr", e), int'(rd_addr), ctab[ti].rd);
                chk($sformatf("e%0d_wr_en", e), int'(wr_en), ctab[ti].we);
                if (ctab[ti].we != 0) begin
                    chk($sformatf("e%0d_wr_addr", e), int'(wr_addr), ctab[ti].wa);
                    chk($sformatf("e%0d_wr_data", e), int'(wr_data), ctab[ti].wd);
                end
                ti++;
            end
            if (wr_en) writes++;
        end
        chk("frame1_writes", writes, 16);
        for (int w = 0; w < 16; w++)
            chk($sformatf("frame1_mem%0d", w), int'(mem[w]), exp1[w]);

        writes = 0;
        repeat (50) begin
            step();
            if (wr_en) writes++;
        end
        chk("done_no_wr_en", writes, 0);
        chk("done_rd_addr_hold", int'(rd_addr), 63);

        // ---- frame 2: extremes, abort during window 5, restart
        // in_mem[a] = a except windows 0..2; elsewhere the max is the bottom-right pixel
        for (int i = 0; i < 64; i++) begin
            in_mem[i] = 8'(i);
            mem[i]    = 8'hEE;
        end
        in_mem[0] = 8'd0;   in_mem[1] = 8'd255; in_mem[8] = 8'd255; in_mem[9] = 8'd0;
        in_mem[2] = 8'd0;   in_mem[3] = 8'd0;   in_mem[10] = 8'd0;  in_mem[11] = 8'd0;
        in_mem[4] = 8'd1;   in_mem[5] = 8'd2;   in_mem[12] = 8'd3;  in_mem[13] = 8'd200;
        exp2[0] = 255;
        exp2[1] = 0;
        exp2[2] = 200;
        for (int w = 3; w < 16; w++) exp2[w] = (w / 4) * 16 + (w % 4) * 2 + 9;

        @(negedge clk) rst = 1'b0;
        step();
        @(negedge clk) rst = 1'b1;
        repeat (30) step();
        chk("abort_wr_en_before", int'(wr_en), 1);
        chk("abort_wr_addr", int'(wr_addr), 5);
        chk("abort_wr_data", int'(wr_data), exp2[5]);
        #2 rst = 1'b0;
        #1;
        chk("abort_wr_en_async", int'(wr_en), 0);
        chk("abort_rd_addr_async", int'(rd_addr), 0);
        repeat (2) step();
        for (int w = 0; w < 5; w++)
            chk($sformatf("abort_kept_mem%0d", w), int'(mem[w]), exp2[w]);
        chk("abort_unwritten_mem5", int'(mem[5]), 8'hEE);

        @(negedge clk) rst = 1'b1;
        step();
        chk("restart_rd_addr", int'(rd_addr), 0);
        writes = 0;
        for (int e = 2; e <= 81; e++) begin
            step();
            if (wr_en) writes++;
        end
        chk("frame2_writes", writes, 16);
        for (int w = 0; w < 16; w++)
            chk($sformatf("frame2_mem%0d", w), int'(mem[w]), exp2[w]);

        // ---- alternate geometry 4x4 / 2x2
        alt_in_mem = '{8'd5, 8'd9, 8'd1, 8'd2, 8'd3, 8'd4, 8'd200, 8'd7,
                       8'd0, 8'd0, 8'd0, 8'd0, 8'd8, 8'd6, 8'd250, 8'd255};
        for (int i = 0; i < 16; i++) alt_mem[i] = 8'h00;
        @(negedge clk) alt_rst = 1'b1;
        writes = 0;
        repeat (21) begin
            step();
            if (alt_wr_en) writes++;
        end
        chk("alt_writes", writes, 4);
        chk("alt_mem0", int'(alt_mem[0]), 9);
        chk("alt_mem1", int'(alt_mem[1]), 200);
        chk("alt_mem2", int'(alt_mem[2]), 8);
        chk("alt_mem3", int'(alt_mem[3]), 255);
        writes = 0;
        repeat (20) begin
            step();
            if (alt_wr_en) writes++;
        end
        chk("alt_done_no_wr_en", writes, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
